// File: rtl/ipml_fifo_pkt_pkg.sv
// Shared definitions for the single-clock packet FIFO: write-side FSM
// encodings and the pointer-width helper.
package ipml_fifo_pkt_pkg;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_PKT     = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

    // One extra pointer bit distinguishes full from empty.
    localparam int PTR_GUARD_BITS = 1;

    function automatic int ptr_width(input int depth_width);
        return depth_width + PTR_GUARD_BITS;
    endfunction

endpackage

// File: rtl/ipml_fifo_pkt_sdpram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
// The read register holds its value while rd_en_i is low.
module ipml_fifo_pkt_sdpram #(
    parameter int WIDTH      = 33,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/ipml_fifo_pkt_sync.sv
// Single-clock FIFO with optional frame commit/drop, FWFT read port and
// a count of complete frames held.
//
// Handshake: a word is written on an edge where wr_en=1 and the write is
// accepted (not full, not discarding, no drop); a word is popped on an edge
// where rd_en=1 and rd_empty=0. rd_data/rd_last are valid whenever rd_empty=0.
module ipml_fifo_pkt_sync
    import ipml_fifo_pkt_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_WIDTH      = 10,
    parameter int PKT_MODE         = 1,
    parameter int ALMOST_FULL_NUM  = 1016,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_last,
    input  logic                   wr_en,
    input  logic                   wr_drop,
    output logic                   wr_full,
    output logic                   almost_full,
    output logic [DEPTH_WIDTH:0]   wr_water_level,
    output logic                   wr_overflow,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_last,
    input  logic                   rd_en,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   rd_water_level,
    output logic [DEPTH_WIDTH:0]   pkt_cnt,
    output wr_state_e              dbg_wr_state
);

    localparam int PW = ptr_width(DEPTH_WIDTH);
    localparam logic [PW-1:0] DEPTH_PTR = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [PW-1:0] AF_LVL    = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_LVL    = PW'(ALMOST_EMPTY_NUM);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    wr_state_e               state_q;
    logic [PW-1:0]           wr_ptr_q, commit_ptr_q, rd_ptr_q, fetch_ptr_q;
    logic                    wr_overflow_q;
    logic                    ram_vld_q, head_vld_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_last_q;
    logic [PW-1:0]           pkt_cnt_q;

    logic [PW-1:0]           wr_level, rd_level, wr_ptr_inc;
    logic                    full, drop_req, wr_accept, commit_last;
    logic                    pop, head_load, ram_free, ram_re;
    logic [DATA_WIDTH:0]     ram_dout;

    // Levels, flags and the read-pipeline steering.
    always_comb begin
        wr_level    = wr_ptr_q - rd_ptr_q;
        rd_level    = commit_ptr_q - rd_ptr_q;
        wr_ptr_inc  = wr_ptr_q + PTR_ONE;
        full        = (wr_level == DEPTH_PTR);
        drop_req    = (PKT_MODE != 0) && wr_drop;
        wr_accept   = wr_en && !full && (state_q != WR_DISCARD) && !drop_req;
        commit_last = wr_accept && wr_last;
        pop         = rd_en && head_vld_q;
        // RAM output moves into the head when the head is empty or leaving.
        head_load   = ram_vld_q && (!head_vld_q || pop);
        ram_free    = !ram_vld_q || head_load;
        ram_re      = (fetch_ptr_q != commit_ptr_q) && ram_free;
    end

    ipml_fifo_pkt_sdpram #(
        .WIDTH      (DATA_WIDTH + 1),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q[DEPTH_WIDTH-1:0]),
        .wr_data_i ({wr_last, wr_data}),
        .rd_en_i   (ram_re),
        .rd_addr_i (fetch_ptr_q[DEPTH_WIDTH-1:0]),
        .rd_data_o (ram_dout)
    );

    // Write FSM: pointer advance, frame commit, drop and overflow discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WR_IDLE;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            wr_overflow_q <= 1'b0;
        end else begin
            wr_overflow_q <= 1'b0;
            if (PKT_MODE == 0) begin
                state_q <= WR_IDLE;
                if (wr_accept) begin
                    wr_ptr_q     <= wr_ptr_inc;
                    commit_ptr_q <= wr_ptr_inc;
                end else if (wr_en && full) begin
                    wr_overflow_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    WR_IDLE, WR_PKT: begin
                        if (wr_drop) begin
                            wr_ptr_q <= commit_ptr_q;
                            state_q  <= WR_IDLE;
                        end else if (wr_en && full) begin
                            // Rewind immediately so the space is usable again.
                            wr_overflow_q <= 1'b1;
                            wr_ptr_q      <= commit_ptr_q;
                            state_q       <= wr_last ? WR_IDLE : WR_DISCARD;
                        end else if (wr_accept) begin
                            wr_ptr_q <= wr_ptr_inc;
                            if (wr_last) begin
                                commit_ptr_q <= wr_ptr_inc;
                                state_q      <= WR_IDLE;
                            end else begin
                                state_q <= WR_PKT;
                            end
                        end
                    end
                    WR_DISCARD: begin
                        if (wr_drop || (wr_en && wr_last)) begin
                            state_q <= WR_IDLE;
                        end
                    end
                    default: state_q <= WR_IDLE;
                endcase
            end
        end
    end

    // Read side: RAM fetch pointer, one-word prefetch head and pop pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            fetch_ptr_q <= '0;
            ram_vld_q   <= 1'b0;
            head_vld_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (ram_re) begin
                fetch_ptr_q <= fetch_ptr_q + PTR_ONE;
                ram_vld_q   <= 1'b1;
            end else if (head_load) begin
                ram_vld_q <= 1'b0;
            end
            if (head_load) begin
                head_vld_q <= 1'b1;
                rd_data_q  <= ram_dout[DATA_WIDTH-1:0];
                rd_last_q  <= ram_dout[DATA_WIDTH];
            end else if (pop) begin
                head_vld_q <= 1'b0;
            end
        end
    end

    // Complete-frame counter: up on a frame-end commit, down on a last-word pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            case ({commit_last, pop && rd_last_q})
                2'b10:   pkt_cnt_q <= pkt_cnt_q + PTR_ONE;
                2'b01:   pkt_cnt_q <= pkt_cnt_q - PTR_ONE;
                default: pkt_cnt_q <= pkt_cnt_q;
            endcase
        end
    end

    assign wr_full        = full;
    assign almost_full    = (wr_level >= AF_LVL);
    assign wr_water_level = wr_level;
    assign wr_overflow    = wr_overflow_q;
    assign rd_data        = rd_data_q;
    assign rd_last        = rd_last_q;
    assign rd_empty       = !head_vld_q;
    assign almost_empty   = (rd_level <= AE_LVL);
    assign rd_water_level = rd_level;
    assign pkt_cnt        = pkt_cnt_q;
    assign dbg_wr_state   = state_q;

endmodule

// File: tb/tb_ipml_fifo_pkt_sync.sv
// Bench for ipml_fifo_pkt_sync: a 16-deep frame-mode instance driven by
// directed and random traffic against a frame-level reference model, and a
// 16-deep plain-mode instance for the full/almost-full/overflow corner.
module tb_ipml_fifo_pkt_sync;
    import ipml_fifo_pkt_pkg::*;

    localparam int W   = 16;
    localparam int DW  = 4;
    localparam int DEP = 16;
    localparam int AF1 = 12;
    localparam int AF0 = 14;
    localparam int AE  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- frame-mode DUT ----------------
    logic [W-1:0] wr_data_1 = '0;
    logic         wr_last_1 = 1'b0, wr_en_1 = 1'b0, wr_drop_1 = 1'b0, rd_en_1 = 1'b0;
    logic         wr_full_1, almost_full_1, wr_overflow_1, rd_last_1, rd_empty_1, almost_empty_1;
    logic [DW:0]  wr_water_level_1, rd_water_level_1, pkt_cnt_1;
    logic [W-1:0] rd_data_1;
    wr_state_e    dbg_wr_state_1;

    ipml_fifo_pkt_sync #(
        .DATA_WIDTH(W), .DEPTH_WIDTH(DW), .PKT_MODE(1),
        .ALMOST_FULL_NUM(AF1), .ALMOST_EMPTY_NUM(AE)
    ) dut1 (
        .clk(clk), .rst(rst),
        .wr_data(wr_data_1), .wr_last(wr_last_1), .wr_en(wr_en_1), .wr_drop(wr_drop_1),
        .wr_full(wr_full_1), .almost_full(almost_full_1), .wr_water_level(wr_water_level_1),
        .wr_overflow(wr_overflow_1), .rd_data(rd_data_1), .rd_last(rd_last_1), .rd_en(rd_en_1),
        .rd_empty(rd_empty_1), .almost_empty(almost_empty_1), .rd_water_level(rd_water_level_1),
        .pkt_cnt(pkt_cnt_1), .dbg_wr_state(dbg_wr_state_1)
    );

    // ---------------- plain-mode DUT ----------------
    logic [W-1:0] wr_data_0 = '0;
    logic         wr_last_0 = 1'b0, wr_en_0 = 1'b0, wr_drop_0 = 1'b0, rd_en_0 = 1'b0;
    logic         wr_full_0, almost_full_0, wr_overflow_0, rd_last_0, rd_empty_0, almost_empty_0;
    logic [DW:0]  wr_water_level_0, rd_water_level_0, pkt_cnt_0;
    logic [W-1:0] rd_data_0;
    wr_state_e    dbg_wr_state_0;

    ipml_fifo_pkt_sync #(
        .DATA_WIDTH(W), .DEPTH_WIDTH(DW), .PKT_MODE(0),
        .ALMOST_FULL_NUM(AF0), .ALMOST_EMPTY_NUM(AE)
    ) dut0 (
        .clk(clk), .rst(rst),
        .wr_data(wr_data_0), .wr_last(wr_last_0), .wr_en(wr_en_0), .wr_drop(wr_drop_0),
        .wr_full(wr_full_0), .almost_full(almost_full_0), .wr_water_level(wr_water_level_0),
        .wr_overflow(wr_overflow_0), .rd_data(rd_data_0), .rd_last(rd_last_0), .rd_en(rd_en_0),
        .rd_empty(rd_empty_0), .almost_empty(almost_empty_0), .rd_water_level(rd_water_level_0),
        .pkt_cnt(pkt_cnt_0), .dbg_wr_state(dbg_wr_state_0)
    );

    // ---------------- reference model state ----------------
    logic [W:0] exp_q[$];    // committed, not yet popped: {last, data}
    logic [W:0] pend_q[$];   // current uncommitted frame
    logic [W:0] exp0_q[$];   // plain-mode FIFO contents
    bit         disc = 1'b0;
    bit         ovf_exp = 1'b0;
    bit         ovf0_exp = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         pops1 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lasts_held();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][W]) n++;
        return n;
    endfunction

    function automatic int lasts_held0();
        int n = 0;
        foreach (exp0_q[i]) if (exp0_q[i][W]) n++;
        return n;
    endfunction

    // ---------------- driver: frame-mode DUT, one clock per call ----------------
    task automatic cyc(input bit we, input bit last, input bit drop, input bit re,
                       input bit rs, input logic [W-1:0] d);
        int lvl;
        lvl = exp_q.size() + pend_q.size();
        chk("wr_level", int'(wr_water_level_1), lvl);
        chk("rd_level", int'(rd_water_level_1), exp_q.size());
        chk("pkt_cnt", int'(pkt_cnt_1), lasts_held());
        chk("overflow", int'(wr_overflow_1), int'(ovf_exp));
        chk("full", int'(wr_full_1), int'(lvl == DEP));
        chk("almost_full", int'(almost_full_1), int'(lvl >= AF1));
        chk("almost_empty", int'(almost_empty_1), int'(exp_q.size() <= AE));
        wr_en_1 = we; wr_last_1 = last; wr_drop_1 = drop; rd_en_1 = re; wr_data_1 = d; rst = rs;
        if (rs) begin
            exp_q.delete(); pend_q.delete(); disc = 1'b0; ovf_exp = 1'b0;
        end else begin
            ovf_exp = 1'b0;
            if (!disc) begin
                if (drop) begin
                    pend_q.delete();
                end else if (we && lvl == DEP) begin
                    ovf_exp = 1'b1;
                    pend_q.delete();
                    if (!last) disc = 1'b1;
                end else if (we) begin
                    pend_q.push_back({last, d});
                    if (last) begin
                        foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                        pend_q.delete();
                    end
                end
            end else if (drop || (we && last)) begin
                disc = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- driver: plain-mode DUT ----------------
    task automatic cyc0(input bit we, input bit last, input bit re, input logic [W-1:0] d);
        chk("p_wr_level", int'(wr_water_level_0), exp0_q.size());
        chk("p_overflow", int'(wr_overflow_0), int'(ovf0_exp));
        chk("p_full", int'(wr_full_0), int'(exp0_q.size() == DEP));
        chk("p_pkt_cnt", int'(pkt_cnt_0), lasts_held0());
        wr_en_0 = we; wr_last_0 = last; rd_en_0 = re; wr_data_0 = d;
        ovf0_exp = we && (exp0_q.size() == DEP);
        if (we && exp0_q.size() < DEP) exp0_q.push_back({last, d});
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors: compare every pop against the model ----------------
    always @(negedge clk) begin
        if (!rst && rd_en_1 && !rd_empty_1) begin
            logic [W:0] e;
            checks++;
            pops1++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop1_unexpected: got %h expected no word", {rd_last_1, rd_data_1});
            end else begin
                e = exp_q.pop_front();
                if ({rd_last_1, rd_data_1} !== e) begin
                    errors++;
                    $display("FAIL pop1_data: got %h expected %h at %0t", {rd_last_1, rd_data_1}, e, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rd_en_0 && !rd_empty_0) begin
            logic [W:0] e;
            checks++;
            if (exp0_q.size() == 0) begin
                errors++;
                $display("FAIL pop0_unexpected: got %h expected no word", {rd_last_0, rd_data_0});
            end else begin
                e = exp0_q.pop_front();
                if ({rd_last_0, rd_data_0} !== e) begin
                    errors++;
                    $display("FAIL pop0_data: got %h expected %h at %0t", {rd_last_0, rd_data_0}, e, $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset values.
        chk("rst_rd_empty", int'(rd_empty_1), 1);
        chk("rst_almost_empty", int'(almost_empty_1), 1);
        chk("rst_full", int'(wr_full_1), 0);
        chk("rst_almost_full", int'(almost_full_1), 0);
        chk("rst_overflow", int'(wr_overflow_1), 0);
        chk("rst_rd_data", int'(rd_data_1), 0);
        chk("rst_rd_last", int'(rd_last_1), 0);
        chk("rst_wr_level", int'(wr_water_level_1), 0);
        chk("rst_rd_level", int'(rd_water_level_1), 0);
        chk("rst_pkt_cnt", int'(pkt_cnt_1), 0);
        chk("rst_state", int'(dbg_wr_state_1), int'(WR_IDLE));
        chk("rst_p_rd_empty", int'(rd_empty_0), 1);
        rst = 1'b0;

        // 5-word frame: visibility two edges after the commit edge.
        for (int i = 0; i < 5; i++) cyc(1, i == 4, 0, 0, 0, 16'h1000 + 16'(i));
        chk("vis_commit_edge", int'(rd_empty_1), 1);
        chk("vis_pkt_cnt", int'(pkt_cnt_1), 1);
        cyc(0, 0, 0, 0, 0, '0);
        chk("vis_edge1", int'(rd_empty_1), 1);
        cyc(0, 0, 0, 0, 0, '0);
        chk("vis_edge2", int'(rd_empty_1), 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, '0);
        chk("burst_no_bubble", exp_q.size(), 0);
        cyc(0, 0, 0, 0, 0, '0);
        chk("burst_empty", int'(rd_empty_1), 1);

        // Drop a partial frame, then a 2-word frame survives intact.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 16'h2000 + 16'(i));
        cyc(0, 0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        chk("drop_level", int'(wr_water_level_1), 0);
        chk("drop_empty", int'(rd_empty_1), 1);
        cyc(1, 0, 0, 0, 0, 16'h2100);
        cyc(1, 1, 0, 0, 0, 16'h2101);
        repeat (3) cyc(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, '0);
        chk("drop_next_frame", exp_q.size(), 0);

        // 20-word frame into a 16-word FIFO: overflow on word 17.
        for (int i = 0; i < 17; i++) cyc(1, 0, 0, 0, 0, 16'h3000 + 16'(i));
        chk("ovf_pulse", int'(wr_overflow_1), 1);
        chk("ovf_level", int'(wr_water_level_1), 0);
        chk("ovf_state", int'(dbg_wr_state_1), int'(WR_DISCARD));
        for (int i = 17; i < 20; i++) cyc(1, i == 19, 0, 0, 0, 16'h3000 + 16'(i));
        chk("ovf_once", int'(wr_overflow_1), 0);
        for (int i = 0; i < 4; i++) cyc(1, i == 3, 0, 0, 0, 16'h3100 + 16'(i));
        repeat (3) cyc(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, '0);
        chk("ovf_next_frame", exp_q.size(), 0);

        // Reset mid-frame with two committed frames stored.
        for (int i = 0; i < 2; i++) cyc(1, i == 1, 0, 0, 0, 16'h4000 + 16'(i));
        for (int i = 0; i < 3; i++) cyc(1, i == 2, 0, 0, 0, 16'h4100 + 16'(i));
        repeat (3) cyc(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0, 16'h4200 + 16'(i));
        cyc(0, 0, 0, 0, 1, '0);
        chk("mrst_empty", int'(rd_empty_1), 1);
        chk("mrst_pkt_cnt", int'(pkt_cnt_1), 0);
        chk("mrst_wr_level", int'(wr_water_level_1), 0);
        chk("mrst_rd_level", int'(rd_water_level_1), 0);
        chk("mrst_state", int'(dbg_wr_state_1), int'(WR_IDLE));

        // Random interleaved traffic in alternating write-heavy / read-heavy phases.
        for (int c = 0; c < 10000; c++) begin
            bit heavy_wr;
            heavy_wr = ((c / 500) % 2) == 0;
            cyc($urandom_range(0, 99) < (heavy_wr ? 90 : 70),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 63) == 0,
                $urandom_range(0, 99) < (heavy_wr ? 40 : 90),
                0, 16'($urandom));
        end
        for (int c = 0; c < 64 && exp_q.size() > 0; c++) cyc(0, 0, 0, 1, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_wraps", int'(pops1 >= 100 * 2 * DEP), 1);

        // Plain mode: fill to full, almost_full at 14, write+pop at full.
        for (int i = 0; i < 16; i++) begin
            cyc0(1, i == 7, 0, 16'h5000 + 16'(i));
            if (i == 12) chk("p_af_below", int'(almost_full_0), 0);
            if (i == 13) begin
                chk("p_af_level", int'(wr_water_level_0), 14);
                chk("p_af_at", int'(almost_full_0), 1);
            end
        end
        chk("p_full_at16", int'(wr_full_0), 1);
        cyc0(1, 0, 1, 16'h5FFF);
        chk("p_full_ovf", int'(wr_overflow_0), 1);
        chk("p_full_level", int'(wr_water_level_0), 15);
        for (int c = 0; c < 40 && exp0_q.size() > 0; c++) cyc0(0, 0, 1, '0);
        cyc0(0, 0, 0, '0);
        chk("p_drained", exp0_q.size(), 0);
        chk("p_pkt_cnt_end", int'(pkt_cnt_0), 0);
        chk("p_rd_empty_end", int'(rd_empty_0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
